// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts one byte per valid/ready handshake and shifts it
// out LSB first, each bit held for CLKS_PER_BIT clocks on an idle-high line.
module uart_tx #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [7:0] iData,
    input  logic       iValid,
    output logic       oReady,
    output logic       oTx,
    output logic       oBusy,
    output logic       oDone,
    output logic [1:0] oState
);
    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state, stateNext;
    logic [15:0] baudCnt, baudCntNext;
    logic [2:0]  bitCnt, bitCntNext;
    logic [7:0]  shiftReg, shiftRegNext;
    logic        txNext, readyNext, busyNext, doneNext;
    logic        bitEnd;

    assign bitEnd = (baudCnt == LAST_CNT);
    assign oState = state;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state    <= IDLE;
            baudCnt  <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            oTx      <= 1'b1;
            oReady   <= 1'b1;
            oBusy    <= 1'b0;
            oDone    <= 1'b0;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudCntNext;
            bitCnt   <= bitCntNext;
            shiftReg <= shiftRegNext;
            oTx      <= txNext;
            oReady   <= readyNext;
            oBusy    <= busyNext;
            oDone    <= doneNext;
        end
    end

    // Handshake: a byte transfers on a rising edge where iValid and oReady are both 1;
    // iValid while oReady is 0 is ignored entirely (nothing is queued).
    always_comb begin
        stateNext    = state;
        baudCntNext  = baudCnt;
        bitCntNext   = bitCnt;
        shiftRegNext = shiftReg;
        txNext       = oTx;
        readyNext    = oReady;
        busyNext     = oBusy;
        doneNext     = 1'b0;

        case (state)
            IDLE: begin
                txNext      = 1'b1;
                readyNext   = 1'b1;
                busyNext    = 1'b0;
                baudCntNext = '0;
                if (iValid && oReady) begin
                    stateNext    = START;
                    shiftRegNext = iData;
                    txNext       = 1'b0;
                    readyNext    = 1'b0;
                    busyNext     = 1'b1;
                    bitCntNext   = '0;
                end
            end
            START: begin
                if (bitEnd) begin
                    stateNext   = DATA;
                    baudCntNext = '0;
                    txNext      = shiftReg[0];
                end else begin
                    baudCntNext = baudCnt + 16'd1;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    baudCntNext  = '0;
                    shiftRegNext = {1'b0, shiftReg[7:1]};
                    bitCntNext   = bitCnt + 3'd1;
                    if (bitCnt == 3'd7) begin
                        stateNext = STOP;
                        txNext    = 1'b1;
                    end else begin
                        // next bit on the line is the one about to land in shiftReg[0]
                        txNext = shiftReg[1];
                    end
                end else begin
                    baudCntNext = baudCnt + 16'd1;
                end
            end
            STOP: begin
                if (bitEnd) begin
                    stateNext   = IDLE;
                    baudCntNext = '0;
                    txNext      = 1'b1;
                    readyNext   = 1'b1;
                    busyNext    = 1'b0;
                    doneNext    = 1'b1;
                end else begin
                    baudCntNext = baudCnt + 16'd1;
                end
            end
            default: begin
                stateNext   = IDLE;
                baudCntNext = '0;
                bitCntNext  = '0;
                txNext      = 1'b1;
                readyNext   = 1'b1;
                busyNext    = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (N=4, 434, 2) driven one at a time; a line
// monitor checks every bit period of every frame against queued expected bytes.
module tb_uart_tx;
    typedef struct packed {
        logic [1:0]  inst;
        logic [7:0]  data;
        logic [15:0] gap;
        logic        abort;
    } ent_t;
    localparam int ENT_W = 27;

    logic       clk;
    logic       rst_n;
    logic [7:0] data [3];
    logic       valid [3];
    logic       ready [3];
    logic       tx [3];
    logic       busy [3];
    logic       done [3];
    logic [1:0] st [3];
    int         nbv [3] = '{4, 434, 2};

    logic [ENT_W-1:0] exp_q[$];
    int   checks = 0;
    int   fails = 0;
    int   async_n = 0;
    logic async_tx = 1'b0;
    bit   end_req = 1'b0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NV = (g == 0) ? 4 : ((g == 1) ? 434 : 2);
        uart_tx #(.CLK_FREQ(50000000), .BAUD(115200), .CLKS_PER_BIT(NV)) u_dut (
            .iClk(clk), .iRst(rst_n), .iData(data[g]), .iValid(valid[g]),
            .oReady(ready[g]), .oTx(tx[g]), .oBusy(busy[g]), .oDone(done[g]),
            .oState(st[g])
        );
    end

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required end_req before it");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic push(input int i, input logic [7:0] d, input int gap, input logic ab);
        ent_t e;
        e.inst  = 2'(i);
        e.data  = d;
        e.gap   = 16'(gap);
        e.abort = ab;
        exp_q.push_back(e);
    endtask

    task automatic send(input int i, input logic [7:0] d, input logic ab);
        @(negedge clk);
        push(i, d, 0, ab);
        data[i]  = d;
        valid[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid[i] = 1'b0;
    endtask

    task automatic send_pair(input int i, input logic [7:0] d0, input logic [7:0] d1);
        @(negedge clk);
        push(i, d0, 0, 1'b0);
        push(i, d1, 10 * nbv[i] + 1, 1'b0);
        data[i]  = d0;
        valid[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data[i] = d1;
        repeat (10 * nbv[i] + 1) @(posedge clk);
        @(negedge clk);
        valid[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // stimulus
    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data[i]  = 8'h00;
            valid[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        send(0, 8'h41, 1'b0);
        idle(45);

        send_pair(0, 8'h55, 8'hAA);
        idle(45);

        send(0, 8'h00, 1'b0);
        idle(12);
        data[0]  = 8'hFF;
        valid[0] = 1'b1;
        idle(3);
        valid[0] = 1'b0;
        idle(40);

        send(0, 8'h00, 1'b1);
        repeat (16) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 async_tx = tx[0];
        async_n++;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        send(0, 8'h3C, 1'b0);
        idle(45);

        send(1, 8'hA5, 1'b0);
        idle(4345);

        send_pair(2, 8'hFF, 8'h00);
        idle(25);

        @(negedge clk);
        #1 end_req = 1'b1;
    end

    // scoreboard monitor
    initial begin
        bit   act [3];
        bit   ok [3];
        int   pos [3];
        int   last_start [3];
        ent_t cur [3];
        int   cyc;
        int   async_chk;
        int   n;
        int   b;
        logic ex;
        bit   leftover;
        cyc       = 0;
        async_chk = 0;
        for (int i = 0; i < 3; i++) begin
            act[i]        = 1'b0;
            ok[i]         = 1'b1;
            pos[i]        = 0;
            last_start[i] = 0;
            cur[i]        = '0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 3; i++) begin
                n = nbv[i];
                if (!rst_n) begin
                    if (act[i]) begin
                        checks++;
                        if (!cur[i].abort) begin
                            fails++;
                            $display("FAIL abort inst%0d: frame 0x%02h cut by reset, required a complete frame", i, cur[i].data);
                        end
                        act[i] = 1'b0;
                    end
                    checks++;
                    if (!(tx[i] === 1'b1 && ready[i] === 1'b1 && busy[i] === 1'b0 && done[i] === 1'b0 && st[i] === 2'd0)) begin
                        fails++;
                        $display("FAIL reset_state inst%0d: tx=%b ready=%b busy=%b done=%b state=%0d, required tx=1 ready=1 busy=0 done=0 state=0",
                                 i, tx[i], ready[i], busy[i], done[i], st[i]);
                    end
                end else begin
                    if (!act[i] && tx[i] === 1'b0) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            fails++;
                            cur[i] = '0;
                            $display("FAIL frame_start inst%0d: start bit at cycle %0d, required no frame", i, cyc);
                        end else begin
                            cur[i] = ent_t'(exp_q.pop_front());
                            if (cur[i].inst != 2'(i)) begin
                                fails++;
                                $display("FAIL frame_start inst%0d: frame began here, required it on inst%0d", i, cur[i].inst);
                            end
                        end
                        if (cur[i].gap != 16'd0) begin
                            checks++;
                            if (cyc - last_start[i] != int'(cur[i].gap)) begin
                                fails++;
                                $display("FAIL frame_gap inst%0d: spacing %0d cycles, required %0d", i, cyc - last_start[i], cur[i].gap);
                            end
                        end
                        last_start[i] = cyc;
                        act[i] = 1'b1;
                        pos[i] = 0;
                    end
                    if (act[i]) begin
                        if (pos[i] == 10 * n) begin
                            checks++;
                            if (!(tx[i] === 1'b1 && done[i] === 1'b1 && ready[i] === 1'b1 && busy[i] === 1'b0 && !cur[i].abort)) begin
                                fails++;
                                $display("FAIL frame_end inst%0d data 0x%02h: tx=%b done=%b ready=%b busy=%b abort=%b, required tx=1 done=1 ready=1 busy=0 abort=0",
                                         i, cur[i].data, tx[i], done[i], ready[i], busy[i], cur[i].abort);
                            end
                            act[i] = 1'b0;
                        end else begin
                            b  = pos[i] / n;
                            ex = (b == 0) ? 1'b0 : ((b == 9) ? 1'b1 : cur[i].data[b-1]);
                            if (pos[i] % n == 0) ok[i] = 1'b1;
                            if (!(tx[i] === ex && busy[i] === 1'b1 && ready[i] === 1'b0 && done[i] === 1'b0)) ok[i] = 1'b0;
                            if (pos[i] % n == n - 1) begin
                                checks++;
                                if (!ok[i]) begin
                                    fails++;
                                    $display("FAIL frame_bit inst%0d data 0x%02h bit%0d: tx=%b busy=%b ready=%b done=%b, required tx=%b busy=1 ready=0 done=0 for %0d cycles",
                                             i, cur[i].data, b, tx[i], busy[i], ready[i], done[i], ex, n);
                                end
                            end
                            pos[i]++;
                        end
                    end else if (done[i] === 1'b1) begin
                        checks++;
                        fails++;
                        $display("FAIL spurious_done inst%0d: done=1 at cycle %0d, required 0 outside frame end", i, cyc);
                    end
                end
            end
            if (async_n != async_chk) begin
                checks++;
                if (async_tx !== 1'b1) begin
                    fails++;
                    $display("FAIL async_reset: tx=%b before any clock edge, required 1", async_tx);
                end
                async_chk = async_n;
            end
            if (end_req) begin
                leftover = act[0] || act[1] || act[2];
                checks++;
                if (exp_q.size() != 0 || leftover) begin
                    fails++;
                    $display("FAIL leftover: %0d frames never seen, active=%b, required 0 and 0", exp_q.size(), leftover);
                end
                $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
                $finish;
            end
        end
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, the iClk frequency in Hz.
REQ-002 Parameter BAUD, default 115200, the line bit rate.
REQ-003 Parameter CLKS_PER_BIT, default CLK_FREQ/BAUD (434), the iClk cycles per serial bit; legal range 2..65535.
REQ-004 iClk  input  1  the single clock; all state changes on its rising edge.
REQ-005 iRst  input  1  reset, asynchronous, active-low.
REQ-006 iData  input  8  byte to transmit; sampled only on the accept cycle.
REQ-007 iValid  input  1  iData is valid and a frame is requested.
REQ-008 oReady  output  1  registered; high only in IDLE, when the block can accept a byte.
REQ-009 oTx  output  1  serial line output, registered, idle-high, 8N1 framing.
REQ-010 oBusy  output  1  registered; high from the accept edge until the frame ends.
REQ-011 oDone  output  1  registered one-cycle pulse when a frame completes.

Function
REQ-012 The block SHALL have four states: IDLE, START, DATA, STOP.
REQ-013 Accept: the block SHALL accept a byte at a rising edge where iValid=1 and oReady=1. On that edge it SHALL latch iData into a shift register and go IDLE->START, with oTx<=0, oReady<=0, oBusy<=1, bit counter<=0, baud counter<=0.
REQ-014 When oReady=0, iValid SHALL be ignored: no queuing and no effect on the frame in flight.
REQ-015 Changes on iData after the accept edge SHALL NOT affect the frame.
REQ-016 Each state SHALL hold oTx for exactly CLKS_PER_BIT cycles. The baud counter SHALL count 0..CLKS_PER_BIT-1, reset to 0 on every bit boundary, and never wrap elsewhere.
REQ-017 START->DATA SHALL occur at baud count CLKS_PER_BIT-1; oTx<=shift[0].
REQ-018 DATA SHALL send bits LSB first, bit 0 through bit 7.
REQ-019 At each DATA bit boundary the shift register SHALL shift right and the bit counter SHALL increment.
REQ-020 After bit 7, DATA->STOP SHALL occur with oTx<=1.
REQ-021 At the end of STOP the block SHALL go STOP->IDLE with oReady<=1, oBusy<=0 and oDone<=1 for exactly one cycle.
REQ-022 Frame timing: oTx low-start spans cycles T..T+N-1, where T is the accept edge and N=CLKS_PER_BIT. Data bit k spans T+(k+1)N..T+(k+2)N-1. Stop spans T+9N..T+10N-1. IDLE is entered at edge T+10N.
REQ-023 Back-to-back: if iValid is held high, the next accept SHALL occur at edge T+10N+1. Minimum frame spacing is therefore 10N+1 cycles, including one idle-high cycle.
REQ-024 oTx SHALL be 1 whenever the state is IDLE or STOP, and SHALL never glitch low outside START or a 0 data bit.
REQ-025 oDone SHALL be 0 in all cycles except the first IDLE cycle after a completed STOP.
REQ-026 Illegal or unreached state encodings SHALL return to IDLE on the next edge with oTx=1.

Reset
REQ-027 While iRst=0, the block SHALL immediately (asynchronously) force: state=IDLE, oTx=1, oReady=1, oBusy=0, oDone=0, all counters and the shift register=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame. oTx SHALL go high without waiting for a clock edge, no oDone SHALL be produced, and the byte SHALL be discarded.
REQ-029 On the first edge after iRst deasserts, the block SHALL be able to accept a byte if iValid=1.

Verification
REQ-030 Scenario, single byte (N=4): iData=0x41, iValid pulsed for 1 cycle -> oTx sequence per 4-cycle bit is 0,1,0,0,0,0,0,1,0,1; oDone pulses exactly once at edge T+40; oBusy is high for 40 cycles.
REQ-031 Scenario, back-to-back (N=4): iValid held high with 0x55 then 0xAA -> second start bit begins at T+41; exactly one idle-high cycle separates the frames; two oDone pulses.
REQ-032 Scenario, busy ignore (N=4): iValid=1 with iData=0xFF pulsed during the DATA state of a 0x00 frame -> the 0x00 frame is unaltered; no extra frame is sent; one oDone.
REQ-033 Scenario, mid-frame reset (N=4): iRst=0 during bit 3 of 0x00 -> oTx=1 within the same cycle with no clock edge; no oDone; after release, sending 0x3C produces a correct frame.
REQ-034 Scenario, default timing (N=434): send 0xA5 -> each bit period measures exactly 434 cycles; the decoded byte is 0xA5; the stop bit is high for 434 cycles.
REQ-035 Scenario, minimum divisor (N=2): send 0xFF and 0x00 back to back -> 21-cycle frame spacing; bits are correct.
